// File: rtl/adjacency_pkg.sv
// Shared types and constants for the adjacency streamer: FSM state encoding,
// load target selectors and configuration register addresses.
package adjacency_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HDR_START = 3'd1,
    S_HDR_END   = 3'd2,
    S_FETCH     = 3'd3,
    S_STREAM    = 3'd4
  } state_t;

  localparam logic [1:0] LOAD_SEL_OFFSET = 2'd0;
  localparam logic [1:0] LOAD_SEL_EDGE   = 2'd1;
  localparam logic [1:0] LOAD_SEL_CFG    = 2'd2;

  localparam int unsigned CFG_ADDR_START0 = 0;
  localparam int unsigned CFG_ADDR_START1 = 1;
  localparam int unsigned CFG_ADDR_END    = 2;

  // The load address must be wide enough to reach both the offset table and the edge memory.
  function automatic int max_width(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adj_ram.sv
// Single write port, asynchronous read RAM used for both the offset table and
// the edge memory. Contents are deliberately not cleared by reset.
module adj_ram
  import adjacency_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/adjacency_streamer.sv
// Feeds the path-count engine: replays the start/end header, then streams each
// requested node's successors with a down-counter ending at 1.
module adjacency_streamer
  import adjacency_pkg::*;
#(
  parameter int PARAM_NODE_IDX_WIDTH  = 10,
  parameter int PARAM_COUNTER_WIDTH   = 4,
  parameter int PARAM_EDGE_ADDR_WIDTH = 12
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start_run,
  input  logic                                  part_sel,
  input  logic                                  done,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]       node_idx,
  input  logic                                  rd_next_node,
  output logic [PARAM_NODE_IDX_WIDTH-1:0]       next_node_idx,
  output logic [PARAM_COUNTER_WIDTH-1:0]        next_node_counter,
  input  logic                                  load_en,
  input  logic [1:0]                            load_sel,
  input  logic [max_width(PARAM_NODE_IDX_WIDTH, PARAM_EDGE_ADDR_WIDTH)-1:0] load_addr,
  input  logic [PARAM_EDGE_ADDR_WIDTH+PARAM_COUNTER_WIDTH-1:0] load_data,
  output logic                                  err_seq,
  output logic                                  err_zero_deg
);

  localparam int NW = PARAM_NODE_IDX_WIDTH;
  localparam int CW = PARAM_COUNTER_WIDTH;
  localparam int EW = PARAM_EDGE_ADDR_WIDTH;
  localparam int AW = max_width(NW, EW);
  localparam int OW = EW + CW;

  state_t          state;
  logic [EW-1:0]   ptr;
  logic [NW-1:0]   cfg_start0;
  logic [NW-1:0]   cfg_start1;
  logic [NW-1:0]   cfg_end;

  logic            load_ok;
  logic            offset_we;
  logic            edge_we;
  logic [OW-1:0]   offset_rdata;
  logic [EW-1:0]   off_base;
  logic [CW-1:0]   off_deg;
  logic [EW-1:0]   edge_raddr;
  logic [NW-1:0]   edge_rdata;

  // Tables may only change while the engine is stopped.
  assign load_ok   = load_en & ~start_run;
  assign offset_we = load_ok && (load_sel == LOAD_SEL_OFFSET);
  assign edge_we   = load_ok && (load_sel == LOAD_SEL_EDGE);

  assign off_base = offset_rdata[OW-1:CW];
  assign off_deg  = offset_rdata[CW-1:0];

  // In S_FETCH the first successor comes straight from the freshly read base;
  // afterwards the registered pointer walks the rest of the list.
  assign edge_raddr = (state == S_FETCH) ? off_base : ptr;

  adj_ram #(
    .ADDR_WIDTH (NW),
    .DATA_WIDTH (OW)
  ) u_offset_ram (
    .clk   (clk),
    .we    (offset_we),
    .waddr (load_addr[NW-1:0]),
    .wdata (load_data),
    .raddr (node_idx),
    .rdata (offset_rdata)
  );

  adj_ram #(
    .ADDR_WIDTH (EW),
    .DATA_WIDTH (NW)
  ) u_edge_ram (
    .clk   (clk),
    .we    (edge_we),
    .waddr (load_addr[EW-1:0]),
    .wdata (load_data[NW-1:0]),
    .raddr (edge_raddr),
    .rdata (edge_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_start0 <= '0;
      cfg_start1 <= '0;
      cfg_end    <= '0;
    end else if (load_ok && (load_sel == LOAD_SEL_CFG)) begin
      if (load_addr == AW'(CFG_ADDR_START0)) begin
        cfg_start0 <= load_data[NW-1:0];
      end else if (load_addr == AW'(CFG_ADDR_START1)) begin
        cfg_start1 <= load_data[NW-1:0];
      end else if (load_addr == AW'(CFG_ADDR_END)) begin
        cfg_end <= load_data[NW-1:0];
      end
    end
  end

  // Everything here freezes while start_run is low so the block stays in
  // lockstep with the engine, which gates its own state the same way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      next_node_idx     <= '0;
      next_node_counter <= '0;
      ptr               <= '0;
      err_seq           <= 1'b0;
      err_zero_deg      <= 1'b0;
    end else if (start_run) begin
      case (state)
        S_IDLE: begin
          if (!done) begin
            next_node_idx     <= part_sel ? cfg_start1 : cfg_start0;
            next_node_counter <= CW'(1);
            state             <= S_HDR_START;
          end
        end
        S_HDR_START: begin
          next_node_idx     <= cfg_end;
          next_node_counter <= CW'(1);
          state             <= S_HDR_END;
        end
        S_HDR_END: begin
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (done) begin
            state <= S_IDLE;
          end else if (!rd_next_node) begin
            err_seq <= 1'b1;
          end else begin
            ptr   <= off_base + EW'(1);
            state <= S_STREAM;
            // A node with no successors still emits one item so the engine sees a terminator.
            if (off_deg == '0) begin
              next_node_idx     <= cfg_end;
              next_node_counter <= CW'(1);
              err_zero_deg      <= 1'b1;
            end else begin
              next_node_idx     <= edge_rdata;
              next_node_counter <= off_deg;
            end
          end
        end
        S_STREAM: begin
          if (next_node_counter == CW'(1)) begin
            state <= S_FETCH;
          end else begin
            next_node_idx     <= edge_rdata;
            next_node_counter <= next_node_counter - CW'(1);
            ptr               <= ptr + EW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adjacency_streamer.sv
// Directed bench for adjacency_streamer: header replay, streaming, address wrap,
// degree-0 and sequence errors, freeze, async reset and done parking.
module tb_adjacency_streamer;
  import adjacency_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start_run;
  logic        part_sel;
  logic        done;
  logic [9:0]  node_idx;
  logic        rd_next_node;
  logic [9:0]  next_node_idx;
  logic [3:0]  next_node_counter;
  logic        load_en;
  logic [1:0]  load_sel;
  logic [11:0] load_addr;
  logic [15:0] load_data;
  logic        err_seq;
  logic        err_zero_deg;

  int total;
  int bad;

  adjacency_streamer #(
    .PARAM_NODE_IDX_WIDTH  (10),
    .PARAM_COUNTER_WIDTH   (4),
    .PARAM_EDGE_ADDR_WIDTH (12)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_run         (start_run),
    .part_sel          (part_sel),
    .done              (done),
    .node_idx          (node_idx),
    .rd_next_node      (rd_next_node),
    .next_node_idx     (next_node_idx),
    .next_node_counter (next_node_counter),
    .load_en           (load_en),
    .load_sel          (load_sel),
    .load_addr         (load_addr),
    .load_data         (load_data),
    .err_seq           (err_seq),
    .err_zero_deg      (err_zero_deg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic run, input logic [9:0] node, input logic rd, input logic dn);
    start_run    = run;
    node_idx     = node;
    rd_next_node = rd;
    done         = dn;
  endtask

  task automatic loadWord(input logic [1:0] sel, input logic [11:0] addr, input logic [15:0] data);
    load_sel  = sel;
    load_addr = addr;
    load_data = data;
    load_en   = 1'b1;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [9:0] exp_idx, input logic [3:0] exp_cnt);
    total++;
    assert ({next_node_idx, next_node_counter} === {exp_idx, exp_cnt}) else begin
      bad++;
      $error("[TB] FAIL %s observed={%0d,%0d} expected={%0d,%0d}", tag,
             next_node_idx, next_node_counter, exp_idx, exp_cnt);
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    part_sel  = 1'b0;
    load_en   = 1'b0;
    load_sel  = 2'd0;
    load_addr = '0;
    load_data = '0;
    applyStimulus(1'b0, 10'd0, 1'b0, 1'b0);

    #12;
    checkOutput("reset_out", 10'd0, 4'd0);
    checkValue("reset_err_seq", 32'(err_seq), 32'd0);
    checkValue("reset_err_zero", 32'(err_zero_deg), 32'd0);
    checkValue("reset_state", 32'(dut.state), 32'(S_IDLE));
    tick();
    rst_n = 1'b1;

    // Configuration, offset entries {base,deg} and edge contents
    loadWord(LOAD_SEL_CFG, 12'd0, 16'd5);
    loadWord(LOAD_SEL_CFG, 12'd1, 16'd9);
    loadWord(LOAD_SEL_CFG, 12'd2, 16'd3);
    loadWord(LOAD_SEL_OFFSET, 12'd9, {12'd20, 4'd3});
    loadWord(LOAD_SEL_OFFSET, 12'd7, {12'd30, 4'd0});
    loadWord(LOAD_SEL_OFFSET, 12'd4, {12'd4094, 4'd3});
    loadWord(LOAD_SEL_EDGE, 12'd20, 16'd7);
    loadWord(LOAD_SEL_EDGE, 12'd21, 16'd8);
    loadWord(LOAD_SEL_EDGE, 12'd22, 16'd3);
    loadWord(LOAD_SEL_EDGE, 12'd4094, 16'd11);
    loadWord(LOAD_SEL_EDGE, 12'd4095, 16'd12);
    loadWord(LOAD_SEL_EDGE, 12'd0, 16'd13);

    // Run with part_sel=1: cycle 0 starts now
    part_sel = 1'b1;
    applyStimulus(1'b1, 10'd0, 1'b0, 1'b0);
    tick();
    checkOutput("hdr_start", 10'd9, 4'd1);
    tick();
    checkOutput("hdr_end", 10'd3, 4'd1);
    tick();
    checkValue("cycle3_fetch", 32'(dut.state), 32'(S_FETCH));
    applyStimulus(1'b1, 10'd9, 1'b1, 1'b0);
    tick();
    checkOutput("stream_c4", 10'd7, 4'd3);
    tick();
    checkOutput("stream_c5", 10'd8, 4'd2);

    // Freeze for four cycles in the middle of the stream
    start_run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("freeze_hold", 10'd8, 4'd2);
    end
    checkValue("freeze_state", 32'(dut.state), 32'(S_STREAM));
    start_run = 1'b1;
    tick();
    checkOutput("stream_c6", 10'd3, 4'd1);
    tick();
    checkValue("cycle7_fetch", 32'(dut.state), 32'(S_FETCH));
    checkOutput("cycle7_hold", 10'd3, 4'd1);

    // Wrapped edge addresses 4094, 4095, 0
    applyStimulus(1'b1, 10'd4, 1'b1, 1'b0);
    tick();
    checkOutput("wrap_0", 10'd11, 4'd3);
    tick();
    checkOutput("wrap_1", 10'd12, 4'd2);
    tick();
    checkOutput("wrap_2", 10'd13, 4'd1);
    tick();
    checkValue("wrap_fetch", 32'(dut.state), 32'(S_FETCH));

    // Degree-0 node
    applyStimulus(1'b1, 10'd7, 1'b1, 1'b0);
    tick();
    checkOutput("deg0_item", 10'd3, 4'd1);
    checkValue("deg0_flag", 32'(err_zero_deg), 32'd1);
    checkValue("deg0_state", 32'(dut.state), 32'(S_STREAM));
    tick();
    checkValue("deg0_back_fetch", 32'(dut.state), 32'(S_FETCH));
    checkValue("err_seq_clear", 32'(err_seq), 32'd0);

    // rd_next_node low in S_FETCH, with a load attempted while running
    applyStimulus(1'b1, 10'd9, 1'b0, 1'b0);
    load_sel  = LOAD_SEL_EDGE;
    load_addr = 12'd20;
    load_data = 16'd99;
    load_en   = 1'b1;
    tick();
    load_en = 1'b0;
    checkValue("seq_flag", 32'(err_seq), 32'd1);
    checkValue("seq_state", 32'(dut.state), 32'(S_FETCH));
    tick();
    checkValue("seq_state_hold", 32'(dut.state), 32'(S_FETCH));
    applyStimulus(1'b1, 10'd9, 1'b1, 1'b0);
    tick();
    checkOutput("load_dropped", 10'd7, 4'd3);

    // Asynchronous reset between clock edges
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out", 10'd0, 4'd0);
    checkValue("async_rst_state", 32'(dut.state), 32'(S_IDLE));
    checkValue("async_rst_flags", 32'({err_seq, err_zero_deg}), 32'd0);
    start_run = 1'b0;
    tick();
    rst_n = 1'b1;

    // Configuration was cleared by reset; reload and run with part_sel=0
    loadWord(LOAD_SEL_CFG, 12'd0, 16'd5);
    loadWord(LOAD_SEL_CFG, 12'd2, 16'd3);
    part_sel = 1'b0;
    applyStimulus(1'b1, 10'd0, 1'b0, 1'b0);
    tick();
    checkOutput("run2_hdr_start", 10'd5, 4'd1);
    tick();
    checkOutput("run2_hdr_end", 10'd3, 4'd1);
    tick();
    checkValue("run2_fetch", 32'(dut.state), 32'(S_FETCH));
    applyStimulus(1'b1, 10'd9, 1'b1, 1'b1);
    tick();
    checkValue("done_idle", 32'(dut.state), 32'(S_IDLE));
    checkOutput("done_hold", 10'd3, 4'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkValue("done_parked", 32'(dut.state), 32'(S_IDLE));
    end
    checkOutput("done_parked_out", 10'd3, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
